// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units (subtractor now, adder planned).
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bi, with borrow out bo.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Optional signed overflow flag (ovf port) when SUB_OVF_FLAG_EN is defined.
//
// Handshake: start is sampled only in IDLE or DONE (busy==0); the accepting edge
// captures a/b. done pulses for one cycle; diff/bout(/ovf) are valid from that
// cycle and hold until the next op commits. start while busy==1 is dropped.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB_OVF_FLAG_EN
  output logic             ovf,
`endif
  output state_t           state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SUB_OVF_FLAG_EN
  logic             sa_q, sa_d, sb_q, sb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             fs_d, fs_bo;
  logic [WIDTH-1:0] shifted;

  full_subtractor u_fs (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // New bit enters at the MSB; after WIDTH shifts the LSB of the result sits at bit 0.
  assign shifted = {fs_d, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SUB_OVF_FLAG_EN
    sa_d    = sa_q;
    sb_d    = sb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          state_d = BUSY;
          busy_d  = 1'b1;
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SUB_OVF_FLAG_EN
          sa_d    = a[WIDTH-1];
          sb_d    = b[WIDTH-1];
`endif
        end
      end
      BUSY: begin
        busy_d = 1'b1;
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        res_d  = shifted[WIDTH-1:1];
        br_d   = fs_bo;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = shifted;
          bout_d  = fs_bo;
`ifdef SUB_OVF_FLAG_EN
          ovf_d   = (sa_q ^ sb_q) & (sa_q ^ fs_d);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUB_OVF_FLAG_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign state_dbg = state_q;
`ifdef SUB_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor; ovf checks compile in with SUB_OVF_FLAG_EN.
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  localparam int W = 8;
  localparam int TIMEOUT = 4 * W;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, bout;
  logic [W-1:0] diff;
  state_t       state_dbg;
`ifdef SUB_OVF_FLAG_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_b_q[$];
  logic         exp_o_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .bout      (bout),
`ifdef SUB_OVF_FLAG_EN
    .ovf       (ovf),
`endif
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operand values.
  function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = (int'(x) - int'(y) + (1 << W)) % (1 << W);
    return r[W-1:0];
  endfunction

  function automatic logic model_bout(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, r;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    r  = sx - sy;
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(model_diff(x, y));
    exp_b_q.push_back(model_bout(x, y));
    exp_o_q.push_back(model_ovf(x, y));
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, bout} !== 3'b000 || diff !== '0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: busy=%b done=%b bout=%b diff=%h state=%0d, required all 0 / IDLE",
               busy, done, bout, diff, state_dbg);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] xs[2];
    logic [W-1:0] ys[2];
    logic [W-1:0] e;
    logic         eb, eo;
    int lat;
    xs[0] = 8'd100; ys[0] = 8'd58;
    xs[1] = 8'd5;   ys[1] = 8'd10;
    for (int i = 0; i < 2; i++) begin
      launch(xs[i], ys[i]);
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL directed_busy[%0d]: busy=%b, required 1", i, busy);
      end
      wait_done(lat);
      e = exp_q.pop_front(); eb = exp_b_q.pop_front(); eo = exp_o_q.pop_front();
      n_vec++;
      if (lat !== W || diff !== e || bout !== eb) begin
        n_err++;
        $display("FAIL directed_result[%0d]: lat=%0d diff=%0d bout=%b, required lat=%0d diff=%0d bout=%b",
                 i, lat, diff, bout, W, e, eb);
      end
`ifdef SUB_OVF_FLAG_EN
      n_vec++;
      if (ovf !== eo) begin
        n_err++;
        $display("FAIL directed_ovf[%0d]: ovf=%b, required %b", i, ovf, eo);
      end
`endif
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || diff !== e || bout !== eb) begin
        n_err++;
        $display("FAIL done_pulse_hold[%0d]: done=%b diff=%0d bout=%b, required done=0 diff=%0d bout=%b",
                 i, done, diff, bout, e, eb);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, e, last;
    logic         eb, eo;
    int lat;
    last = diff;
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom_range(0, (1 << W) - 1));
      y = W'($urandom_range(0, (1 << W) - 1));
      if (i % 6 == 0) x = y;
      launch(x, y);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_vec++;
      if (done === 1'b0 && (busy !== 1'b1 || diff !== last)) begin
        n_err++;
        $display("FAIL random_busy_hold[%0d]: busy=%b diff=%0d, required busy=1 diff=%0d", i, busy, diff, last);
      end
      wait_done(lat);
      e = exp_q.pop_front(); eb = exp_b_q.pop_front(); eo = exp_o_q.pop_front();
      n_vec++;
      if (diff !== e || bout !== eb) begin
        n_err++;
        $display("FAIL random_result[%0d]: a=%0d b=%0d diff=%0d bout=%b, required diff=%0d bout=%b",
                 i, x, y, diff, bout, e, eb);
      end
`ifdef SUB_OVF_FLAG_EN
      n_vec++;
      if (ovf !== eo) begin
        n_err++;
        $display("FAIL random_ovf[%0d]: a=%h b=%h ovf=%b, required %b", i, x, y, ovf, eo);
      end
`endif
      last = e;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    logic         eb, eo;
    int lat;
    launch(8'd255, 8'd255);
    wait_done(lat);
    e = exp_q.pop_front(); eb = exp_b_q.pop_front(); eo = exp_o_q.pop_front();
    n_vec++;
    if (diff !== e || bout !== eb) begin
      n_err++;
      $display("FAIL b2b_first: diff=%0d bout=%b, required diff=%0d bout=%b", diff, bout, e, eb);
    end
    // Start raised in the DONE cycle itself.
    launch(8'd0, 8'd0);
    wait_done(lat);
    e = exp_q.pop_front(); eb = exp_b_q.pop_front(); eo = exp_o_q.pop_front();
    n_vec++;
    if (lat + 1 !== W + 1 || diff !== e || bout !== eb) begin
      n_err++;
      $display("FAIL b2b_second: gap=%0d diff=%0d bout=%b, required gap=%0d diff=%0d bout=%b",
               lat + 1, diff, bout, W + 1, e, eb);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    logic [W-1:0] e;
    logic         eb, eo;
    int lat, spurious;
    launch(8'd100, 8'd58);
    repeat (2) @(negedge clk);
    a = 8'd1;
    b = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    e = exp_q.pop_front(); eb = exp_b_q.pop_front(); eo = exp_o_q.pop_front();
    n_vec++;
    if (lat + 3 !== W || diff !== e || bout !== eb) begin
      n_err++;
      $display("FAIL ignored_start_result: lat=%0d diff=%0d bout=%b, required lat=%0d diff=%0d bout=%b",
               lat + 3, diff, bout, W, e, eb);
    end
    spurious = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    n_vec++;
    if (spurious !== 0) begin
      n_err++;
      $display("FAIL ignored_start_queued: %0d busy/done cycles seen, required 0", spurious);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    logic         eb, eo;
    int lat, spurious;
    launch(8'd37, 8'd200);
    e = exp_q.pop_front(); eb = exp_b_q.pop_front(); eo = exp_o_q.pop_front();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, bout} !== 3'b000 || diff !== '0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b bout=%b diff=%h state=%0d, required all 0 / IDLE",
               busy, done, bout, diff, state_dbg);
    end
`ifdef SUB_OVF_FLAG_EN
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_ovf: ovf=%b, required 0", ovf);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    spurious = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0) spurious++;
    end
    n_vec++;
    if (spurious !== 0) begin
      n_err++;
      $display("FAIL reset_mid_done: %0d done pulses after abort, required 0", spurious);
    end
    launch(8'd200, 8'd37);
    wait_done(lat);
    e = exp_q.pop_front(); eb = exp_b_q.pop_front(); eo = exp_o_q.pop_front();
    n_vec++;
    if (lat !== W || diff !== e || bout !== eb) begin
      n_err++;
      $display("FAIL reset_recover: lat=%0d diff=%0d bout=%b, required lat=%0d diff=%0d bout=%b",
               lat, diff, bout, W, e, eb);
    end
    @(negedge clk);
  endtask

`ifdef SUB_OVF_FLAG_EN
  task automatic test_ovf();
    logic [W-1:0] xs[2];
    logic [W-1:0] ys[2];
    logic [W-1:0] e;
    logic         eb, eo;
    int lat;
    xs[0] = 8'h80; ys[0] = 8'h01;
    xs[1] = 8'h03; ys[1] = 8'h01;
    for (int i = 0; i < 2; i++) begin
      launch(xs[i], ys[i]);
      wait_done(lat);
      e = exp_q.pop_front(); eb = exp_b_q.pop_front(); eo = exp_o_q.pop_front();
      n_vec++;
      if (diff !== e || ovf !== eo) begin
        n_err++;
        $display("FAIL ovf_flag[%0d]: diff=%h ovf=%b, required diff=%h ovf=%b", i, diff, ovf, e, eo);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
`ifdef SUB_OVF_FLAG_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
